// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   seg7_t    : active-low segment vector, bit6=a ... bit0=g
//   SEG_BLANK : all segments off
//   HEX7      : hex nibble -> active-low segment pattern
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t HEX7 [0:15] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
//   nib : input  [3:0] hex digit
//   seg : output seg7_t active-low segments (bit6=a ... bit0=g)
module hex7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output seg7_t      seg
);

    always_comb begin
        seg = HEX7[nib];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for a DIGITS-wide hex 7-segment display with a
// scan prescaler, double-buffered (tear-free) updates, per-digit enable and
// leading-zero blanking.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe capturing value into the pending buffer
//   value      : 4*DIGITS hex digits, nibble k shown on digit k
//   digit_en   : per-digit enable, 0 forces the digit dark (live)
//   blank_lz   : 1 enables leading-zero blanking (live)
//   an_n       : active-low one-hot anode select
//   seg_n      : active-low segments, bit6=a ... bit0=g
//   frame_done : one-cycle pulse after each scan wrap to digit 0
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  frame_done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   pending;
    logic                  pending_valid;
    logic [4*DIGITS-1:0]   disp;
    logic                  disp_valid;

    logic                  tick;
    logic                  wrap;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc         <= '0;
            idx           <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            disp          <= '0;
            disp_valid    <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + PW'(1);
            frame_done <= wrap;

            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end

            if (wrap) begin
                // A load landing on the wrap bypasses pending and supersedes it.
                if (load) begin
                    disp       <= value;
                    disp_valid <= 1'b1;
                end else if (pending_valid) begin
                    disp       <= pending;
                    disp_valid <= 1'b1;
                end
                pending_valid <= 1'b0;
            end else if (load) begin
                pending       <= value;
                pending_valid <= 1'b1;
            end
        end
    end

    logic [3:0]        nib;
    logic              en_sel;
    logic              upper_zero;
    logic              lz;
    logic              dark;
    logic [DIGITS-1:0] onehot;
    seg7_t             dec_seg;

    // Digit select, enable select and the "this digit and all above are
    // zero" test are unrolled per digit instead of using variable slices,
    // so only in-range digits are ever addressed.
    always_comb begin
        nib        = '0;
        en_sel     = 1'b0;
        upper_zero = 1'b1;
        onehot     = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                nib       = disp[4*k +: 4];
                en_sel    = digit_en[k];
                onehot[k] = 1'b1;
            end
            if ((IW'(k) >= idx) && (disp[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        lz   = blank_lz && (idx != '0) && upper_zero;
        dark = !disp_valid || !en_sel || lz;
    end

    hex7_decode u_hex7_decode (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        an_n  = '1;
        seg_n = SEG_BLANK;
        if (!dark) begin
            an_n  = ~onehot;
            seg_n = dec_seg;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        load1;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_done;
    logic [3:0]  an_n1;
    logic [6:0]  seg_n1;
    logic        frame_done1;

    int tests;
    int fails;

    seg7_scan_ctrl #(.DIGITS(4), .PRESCALE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_done (frame_done)
    );

    seg7_scan_ctrl #(.DIGITS(4), .PRESCALE(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load1),
        .value      (value),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .an_n       (an_n1),
        .seg_n      (seg_n1),
        .frame_done (frame_done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pulse(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Advance until the cycle right after a wrap (frame_done high).
    task automatic wait_wrap(input string name);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (frame_done !== 1'b1 && i < 40);
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL %s wait_wrap: frame_done=%b after %0d cycles, required 1", name, frame_done, i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset: an_n=%b seg_n=%b fd=%b, required 1111 1111111 0", an_n, seg_n, frame_done);
        end
        tests++;
        if (an_n1 !== 4'b1111 || seg_n1 !== 7'b1111111 || frame_done1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_p1: an_n=%b seg_n=%b fd=%b, required 1111 1111111 0", an_n1, seg_n1, frame_done1);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        logic exp_fd;
        for (int n = 1; n <= 20; n++) begin
            step();
            exp_fd = (n % 8 == 0);
            tests++;
            if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
                fails++;
                $display("FAIL idle_dark n=%0d: an_n=%b seg_n=%b, required 1111 1111111", n, an_n, seg_n);
            end
            tests++;
            if (frame_done !== exp_fd) begin
                fails++;
                $display("FAIL idle_fd n=%0d: frame_done=%b, required %b", n, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        int         i;
        es = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        load_pulse(16'h12AF);
        i = 0;
        while (frame_done !== 1'b1 && i < 20) begin
            tests++;
            if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
                fails++;
                $display("FAIL midframe_hold i=%0d: an_n=%b seg_n=%b, required 1111 1111111", i, an_n, seg_n);
            end
            step();
            i++;
        end
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL midframe_wrap: frame_done=%b, required 1", frame_done);
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            tests++;
            if (an_n !== ea[c/2] || seg_n !== es[c/2]) begin
                fails++;
                $display("FAIL midframe_frame c=%0d: an_n=%b seg_n=%b, required %b %b", c, an_n, seg_n, ea[c/2], es[c/2]);
            end
            if (c > 0) begin
                tests++;
                if (frame_done !== 1'b0) begin
                    fails++;
                    $display("FAIL midframe_fd c=%0d: frame_done=%b, required 0", c, frame_done);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        blank_lz = 1'b1;
        es = '{7'b0000001, 7'b0000110, 7'b1111111, 7'b1111111};
        ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        load_pulse(16'h0030);
        wait_wrap("lz_0030");
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            tests++;
            if (an_n !== ea[c/2] || seg_n !== es[c/2]) begin
                fails++;
                $display("FAIL lz_0030 c=%0d: an_n=%b seg_n=%b, required %b %b", c, an_n, seg_n, ea[c/2], es[c/2]);
            end
        end
        es = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
        ea = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        load_pulse(16'h0000);
        wait_wrap("lz_0000");
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            tests++;
            if (an_n !== ea[c/2] || seg_n !== es[c/2]) begin
                fails++;
                $display("FAIL lz_0000 c=%0d: an_n=%b seg_n=%b, required %b %b", c, an_n, seg_n, ea[c/2], es[c/2]);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_last_wins();
        logic [3:0] ea [4];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        step();
        load_pulse(16'h1111);
        load_pulse(16'h2222);
        // Still inside the old frame: idx1 must show the old 0.
        tests++;
        if (an_n !== 4'b1101 || seg_n !== 7'b0000001) begin
            fails++;
            $display("FAIL last_wins_hold: an_n=%b seg_n=%b, required 1101 0000001", an_n, seg_n);
        end
        wait_wrap("last_wins");
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            tests++;
            if (an_n !== ea[c/2] || seg_n !== 7'b0010010) begin
                fails++;
                $display("FAIL last_wins c=%0d: an_n=%b seg_n=%b, required %b 0010010", c, an_n, seg_n, ea[c/2]);
            end
        end
    endtask

    task automatic test_coincident();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        es = '{7'b0110001, 7'b0000110, 7'b0001000, 7'b0100100};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        step();
        load_pulse(16'h7777);
        for (int i = 0; i < 6; i++) step();
        tests++;
        if (an_n !== 4'b0111 || seg_n !== 7'b0010010) begin
            fails++;
            $display("FAIL coinc_hold: an_n=%b seg_n=%b, required 0111 0010010", an_n, seg_n);
        end
        load_pulse(16'h5A3C);
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL coinc_wrap: frame_done=%b, required 1", frame_done);
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            tests++;
            if (an_n !== ea[c/2] || seg_n !== es[c/2]) begin
                fails++;
                $display("FAIL coinc_frame c=%0d: an_n=%b seg_n=%b, required %b %b", c, an_n, seg_n, ea[c/2], es[c/2]);
            end
        end
        step();
        tests++;
        if (frame_done !== 1'b1 || an_n !== 4'b1110 || seg_n !== 7'b0110001) begin
            fails++;
            $display("FAIL coinc_discard: fd=%b an_n=%b seg_n=%b, required 1 1110 0110001", frame_done, an_n, seg_n);
        end
    endtask

    task automatic test_digit_en();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        es = '{7'b1111111, 7'b0000000, 7'b1111111, 7'b0000000};
        ea = '{4'b1111, 4'b1101, 4'b1111, 4'b0111};
        digit_en = 4'b1010;
        load_pulse(16'h8888);
        wait_wrap("digit_en");
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            tests++;
            if (an_n !== ea[c/2] || seg_n !== es[c/2]) begin
                fails++;
                $display("FAIL digit_en c=%0d: an_n=%b seg_n=%b, required %b %b", c, an_n, seg_n, ea[c/2], es[c/2]);
            end
        end
        // digit_en acts without a clock edge.
        digit_en = 4'b0111;
        #1;
        tests++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
            fails++;
            $display("FAIL digit_en_live: an_n=%b seg_n=%b, required 1111 1111111", an_n, seg_n);
        end
        digit_en = 4'b1111;
    endtask

    task automatic test_prescale1();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        int         i;
        es = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        value = 16'h4321;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        i = 0;
        do begin
            step();
            i++;
        end while (frame_done1 !== 1'b1 && i < 20);
        tests++;
        if (frame_done1 !== 1'b1) begin
            fails++;
            $display("FAIL p1_wrap: frame_done=%b, required 1", frame_done1);
        end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            tests++;
            if (an_n1 !== ea[c] || seg_n1 !== es[c] || frame_done1 !== (c == 0)) begin
                fails++;
                $display("FAIL p1_frame c=%0d: an_n=%b seg_n=%b fd=%b, required %b %b %b", c, an_n1, seg_n1, frame_done1, ea[c], es[c], (c == 0));
            end
        end
    endtask

    task automatic test_async_reset();
        wait_wrap("areset_pre");
        tests++;
        if (an_n !== 4'b1110 || seg_n !== 7'b0000000) begin
            fails++;
            $display("FAIL areset_pre: an_n=%b seg_n=%b, required 1110 0000000", an_n, seg_n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL areset_now: an_n=%b seg_n=%b fd=%b, required 1111 1111111 0", an_n, seg_n, frame_done);
        end
        #10;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            tests++;
            if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
                fails++;
                $display("FAIL areset_dark n=%0d: an_n=%b seg_n=%b, required 1111 1111111", n, an_n, seg_n);
            end
        end
        load_pulse(16'h0009);
        wait_wrap("areset_reload");
        tests++;
        if (an_n !== 4'b1110 || seg_n !== 7'b0000100) begin
            fails++;
            $display("FAIL areset_reload: an_n=%b seg_n=%b, required 1110 0000100", an_n, seg_n);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        load1    = 1'b0;
        value    = 16'h0000;
        digit_en = 4'b1111;
        blank_lz = 1'b0;

        test_reset();
        test_idle();
        test_load_midframe();
        test_lz();
        test_last_wins();
        test_coincident();
        test_digit_en();
        test_prescale1();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed driver for a DIGITS-wide hex 7-segment display.
- Takes a DIGITS*4-bit value and drives one digit per scan slot, using active-low segments and active-low anodes.
- Adds a scan prescaler, tear-free double-buffered updates, per-digit enable and leading-zero blanking.
- Sits between CPU/board-level status registers and the board display pins.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- PRESCALE, 1000, clock cycles per digit slot (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe that captures value into the pending buffer.
- value  in  4*DIGITS  hex digits; nibble k is shown on digit k, digit 0 is least significant.
- digit_en  in  DIGITS  per-digit enable; 0 forces that digit dark.
- blank_lz  in  1  1 enables leading-zero blanking.
- an_n  out  DIGITS  active-low one-hot anode select.
- seg_n  out  7  active-low segments; bit6=a ... bit0=g.
- frame_done  out  1  one-cycle pulse on each scan wrap to digit 0.

Behaviour:
- State registers:
  - presc: width $clog2(PRESCALE), min 1.
  - idx: width $clog2(DIGITS), min 1.
  - pending: 4*DIGITS bits, plus pending_valid.
  - disp: 4*DIGITS bits, plus disp_valid.
  - frame_done: registered.
- Reset (async, rst_n=0): all registers cleared. an_n=all 1, seg_n=7'b1111111, frame_done=0. Reset mid-frame clears immediately with no partial commit.
- Prescaler:
  - presc counts 0..PRESCALE-1 and wraps.
  - tick = (presc==PRESCALE-1).
  - PRESCALE=1 gives a tick every cycle.
- Scan:
  - On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - On the wrap (tick and idx==DIGITS-1), frame_done <= 1 for exactly one cycle; otherwise frame_done <= 0.
- Buffering:
  - load=1 with no wrap this cycle: pending <= value, pending_valid <= 1. A repeated load overwrites pending; the last load wins.
  - Wrap with pending_valid=1: disp <= pending, disp_valid <= 1, pending_valid <= 0.
  - load coincident with wrap: value goes directly to disp, disp_valid <= 1, pending_valid <= 0. Any older pending is discarded.
  - disp changes only at the wrap, so a frame never mixes old and new digits.
- Output (combinational from registers, zero latency relative to idx/disp):
  - nib = disp[4*idx +: 4].
  - lz = blank_lz && idx!=0 && disp[4*DIGITS-1 : 4*idx] == 0. Digit 0 is never LZ-blanked.
  - dark = !disp_valid || !digit_en[idx] || lz.
  - dark: an_n = all 1, seg_n = 7'b1111111.
  - otherwise: an_n = ~(1<<idx), seg_n = HEX7(nib).
- HEX7 table (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- digit_en and blank_lz are sampled live each cycle and are not buffered.
- Widths: idx compares against DIGITS-1 explicitly, so non-power-of-two DIGITS never reaches an out-of-range index.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'b1111111.
  - HEX7 16-entry constant table as above.
  - typedef seg7_t = logic [6:0].
- Sub-module hex7_decode: combinational nibble -> seg7_t lookup from the package table. Instantiated once on the muxed nibble.
- The scan, prescale and buffer logic stay in seg7_scan_ctrl.

Test Plan:
- Reset, then run 20 cycles with no load (DIGITS=4, PRESCALE=2) -> an_n=4'b1111, seg_n=1111111 throughout; frame_done pulses every 8 cycles.
- load value=16'h12AF at mid-frame -> display unchanged until next frame_done. From the wrap: idx0 shows F=0111000/an_n=1110, idx1 A=0001000/1101, idx2 2=0010010/1011, idx3 1=1001111/0111; each slot lasts 2 cycles.
- blank_lz=1, value=16'h0030 -> digits 3 and 2 dark (an_n=1111), digit1 shows 3=0000110, digit0 shows 0=0000001. value=16'h0000 -> only digit 0 lit, showing 0.
- Loads 16'h1111 then 16'h2222 within one frame -> next frame shows 2 on all digits. load coincident with the wrap cycle -> that value is shown from idx 0 of the new frame.
- digit_en=4'b1010 with value=16'h8888 -> digits 1 and 3 show 0000000; digits 0 and 2 dark. PRESCALE=1 -> idx advances every cycle.
- Assert rst_n=0 asynchronously mid-slot -> outputs go to all-1 and frame_done=0 immediately, without a clock edge. After release, blank until the next load plus wrap.
